// File: rtl/mealy_101_pkg.sv
// State encoding and widths shared by the "101" pattern detector.
`timescale 1ns/1ps
package mealy_101_pkg;

    localparam int unsigned STATE_W = 2;

    // 2'b11 is intentionally unnamed: it is illegal and recovers to S_IDLE.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'b00,
        S_1    = 2'b01,
        S_10   = 2'b10
    } state_t;

endpackage : mealy_101_pkg

// File: rtl/mealy_101.sv
// Mealy detector for the serial pattern "101"; y is combinational from state and x.
`timescale 1ns/1ps
module mealy_101
    import mealy_101_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic x,
    input  logic clk,
    input  logic rst,
    output logic y
);

    state_t state_q;
    state_t state_d;

    // State register; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and detect flag; the illegal code falls back to idle with y low.
    always_comb begin
        state_d = S_IDLE;
        y       = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = x ? S_1 : S_IDLE;
            end
            S_1: begin
                state_d = x ? S_1 : S_10;
            end
            S_10: begin
                y = x;
                if (x) begin
                    state_d = OVERLAP ? S_1 : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                y       = 1'b0;
            end
        endcase
    end

endmodule : mealy_101

// File: tb/tb_mealy_101.sv
// Scoreboard bench for mealy_101: overlapping and non-overlapping instances side by side.
`timescale 1ns/1ps
module tb_mealy_101;
    import mealy_101_pkg::*;

    localparam int unsigned CLK_HALF = 5;
    localparam int unsigned N_RANDOM = 600;

    typedef struct {
        logic ov;
        logic no;
        int   idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic x   = 1'b1;
    logic y_ov;
    logic y_no;

    int checks   = 0;
    int failures = 0;
    int bit_idx  = 0;

    exp_t sb_q[$];
    bit   hist_ov[$];
    bit   hist_no[$];

    always #CLK_HALF clk = ~clk;

    mealy_101 #(.OVERLAP(1'b1)) dut_ov (.x(x), .clk(clk), .rst(rst), .y(y_ov));
    mealy_101 #(.OVERLAP(1'b0)) dut_no (.x(x), .clk(clk), .rst(rst), .y(y_no));

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input state_t act, input state_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: state got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference: a match happens when the bits seen so far end in "10" and the new bit is 1.
    function automatic bit ends_10(input bit h[$]);
        return (h.size() >= 2) && h[h.size()-2] && !h[h.size()-1];
    endfunction

    // Present bit b now and record what y must be before the coming edge.
    task automatic issue(input bit b);
        exp_t e;
        x     = b;
        e.ov  = ends_10(hist_ov) && b;
        e.no  = ends_10(hist_no) && b;
        e.idx = bit_idx;
        bit_idx++;
        sb_q.push_back(e);
        hist_ov.push_back(b);
        if (hist_ov.size() > 2) void'(hist_ov.pop_front());
        if (e.no) begin
            hist_no.delete();
        end else begin
            hist_no.push_back(b);
            if (hist_no.size() > 2) void'(hist_no.pop_front());
        end
    endtask

    task automatic drive_bit(input bit b);
        @(negedge clk);
        issue(b);
    endtask

    task automatic drive_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            drive_bit(s[i] == "1");
        end
    endtask

    // Assert reset with x=1, confirm idle/quiet output, release while presenting a 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        x   = 1'b1;
        hist_ov.delete();
        hist_no.delete();
        #1;
        check_bit("reset y_ov", y_ov, 1'b0);
        check_bit("reset y_no", y_no, 1'b0);
        #3;
        check_state("reset state_ov", dut_ov.state_q, S_IDLE);
        check_state("reset state_no", dut_no.state_q, S_IDLE);
        repeat (2) @(negedge clk);
        check_bit("reset hold y_ov", y_ov, 1'b0);
        rst = 1'b1;
        issue(1'b0);
    endtask

    // Monitor: y is compared just before each rising edge, when the consumer samples it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_bit($sformatf("y_ov bit%0d", e.idx), y_ov, e.ov);
                check_bit($sformatf("y_no bit%0d", e.idx), y_no, e.no);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        // Power-on reset, then 0,1,0,1.
        do_reset();
        drive_str("0101");

        // Basic match followed by a 1: both variants land in S_1.
        do_reset();
        drive_str("1011");
        @(posedge clk);
        #1;
        check_state("after 1011 state_ov", dut_ov.state_q, S_1);
        check_state("after 1011 state_no", dut_no.state_q, S_1);

        // Overlap vs non-overlap, and near-misses.
        do_reset();
        drive_str("10101");
        do_reset();
        drive_str("1101");
        do_reset();
        drive_str("1001");
        do_reset();
        drive_str("000");
        do_reset();
        drive_str("1010101101");

        // Reset mid-match: y must fall without an edge.
        do_reset();
        drive_str("10");
        @(negedge clk);
        x = 1'b1;
        #1;
        check_bit("pre-reset y_ov", y_ov, 1'b1);
        check_bit("pre-reset y_no", y_no, 1'b1);
        rst = 1'b0;
        hist_ov.delete();
        hist_no.delete();
        #1;
        check_bit("async reset y_ov", y_ov, 1'b0);
        check_bit("async reset y_no", y_no, 1'b0);
        check_state("async reset state_ov", dut_ov.state_q, S_IDLE);
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1);
        drive_str("01");

        // x toggling between edges moves y only, never the state.
        do_reset();
        drive_str("10");
        @(negedge clk);
        x = 1'b0;
        #1;
        check_bit("toggle0 y_ov", y_ov, 1'b0);
        x = 1'b1;
        #1;
        check_bit("toggle1 y_ov", y_ov, 1'b1);
        check_bit("toggle1 y_no", y_no, 1'b1);
        check_state("toggle1 state_ov", dut_ov.state_q, S_10);
        x = 1'b0;
        #1;
        check_bit("toggle2 y_ov", y_ov, 1'b0);
        check_state("toggle2 state_no", dut_no.state_q, S_10);

        // Random stream with sparse resets.
        do_reset();
        for (int i = 0; i < N_RANDOM; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                drive_bit(1'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: %0d left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mealy_101

// File: doc/mealy_101.md
Name: mealy_101

Overview:
- Mealy finite-state machine that detects the serial bit pattern "101" on a 1-bit input stream, sampled on rising clock edges.
- Output y is combinational from current state and current input. It asserts in the same cycle the final "1" is present, before that edge is taken.
- Leaf control block, used standalone or as a pattern flag feeding downstream logic.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (the final "1" of a match may start the next match); 0 = non-overlapping (the FSM restarts from idle after a match).

Ports:
- clk  input  1  system clock; all state updates occur on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 forces the idle state immediately.
- x    input  1  serial data bit, sampled at each rising clk edge.
- y    output 1  detect flag; 1 when the current state is S_10 and x==1.
- Positional declaration order is fixed as x, clk, rst, y. Existing instantiations connect by position.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst==0 resets); release is synchronous to the next clk rising edge in effect.
- States:
  - S_IDLE: no progress.
  - S_1: last relevant bit was 1.
  - S_10: "10" seen.
  - Encoding: 2-bit binary, IDLE=2'b00, S_1=2'b01, S_10=2'b10. 2'b11 is illegal and recovers to S_IDLE on the next edge with y=0.
- Transitions on clk rising edge:
  - S_IDLE: x=1 -> S_1; x=0 -> S_IDLE.
  - S_1: x=0 -> S_10; x=1 -> S_1 (a run of 1s keeps the partial match).
  - S_10: x=1 -> S_1 if OVERLAP=1, S_IDLE if OVERLAP=0; x=0 -> S_IDLE.
- Output: y = (state==S_10) & x, purely combinational, zero latency from x.
  - y may glitch with x mid-cycle. Consumers sample y on the clk edge only.
- Reset:
  - While rst==0: state=S_IDLE, y=0 regardless of x.
  - Reset asserted mid-sequence discards partial progress. After release a full fresh "101" is required.
- x changing between edges affects only y, never the state.
- No handshake, no enable. Every clk edge consumes one bit.

Decomposition:
- Package mealy_101_pkg:
  - state typedef/localparams S_IDLE, S_1, S_10 with the encoding above.
  - STATE_W=2.
- Single module with a sequential state register (async active-low reset) and combinational next-state/output logic. No sub-module warranted.

Test Plan:
- Reset: hold rst=0 for 5 ns with x=1 -> y=0 and state=S_IDLE throughout. Release rst=1; bits 0,1,0,1 on successive edges -> y=1 only while the 4th bit (1) is presented with state S_10.
- Basic match: bits 1,0,1 -> y=0 during bits 1 and 2, y=1 during bit 3. Next edge with x=1 -> state S_1, y=0.
- Overlap (OVERLAP=1): bits 1,0,1,0,1 -> y=1 during bits 3 and 5 (two pulses). The same stream with OVERLAP=0 -> y=1 during bit 3 only.
- Near-misses: 1,1,0,1 -> one pulse on bit 4 (S_1 self-loop). 1,0,0,1 -> no pulse. 0,0,0 -> y stays 0.
- Mid-operation reset: reach S_10, drive x=1, then assert rst=0 asynchronously between edges -> y drops to 0 immediately, without waiting for an edge. After release, bit 1 alone -> y=0.
- Combinational timing: in S_10, toggle x 0->1->0 between edges -> y follows x with no clock delay, and state is unchanged until the next edge.
